multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 140 ++++++++++++++
 tb/tb_multicycle_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle ARM-subset control unit: state register plus combinational decode
// Outputs depend only on the registered state and the current instruction fields.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       CondEx,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] FlagWrite,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_cmd;
    logic       w_is_cmp;
    logic       w_pc_dest;
    logic       w_pcw, w_irw, w_rw, w_mw;
    logic [1:0] w_fw;

    assign w_cmd     = Funct[4:1];
    assign w_is_cmp  = (w_cmd == 4'b1010);
    assign w_pc_dest = (Rd == 4'b1111);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = S_FETCH;
        w_pcw      = 1'b0;
        w_irw      = 1'b0;
        w_rw       = 1'b0;
        w_mw       = 1'b0;
        w_fw       = 2'b00;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_next    = S_DECODE;
                w_irw     = 1'b1;
                w_pcw     = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
                ALUSrcB = 2'b01;
            end
            S_MEMRD: begin
                w_next = S_MEMWB;
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                w_rw      = CondEx;
                w_pcw     = CondEx & w_pc_dest;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                w_mw   = CondEx;
            end
            S_EXECR, S_EXECI: begin
                w_next  = w_is_cmp ? S_FETCH : S_ALUWB;
                ALUSrcB = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                case (w_cmd)
                    4'b0010, 4'b1010: ALUControl = 2'b01;
                    4'b0000:          ALUControl = 2'b10;
                    4'b1100:          ALUControl = 2'b11;
                    default:          ALUControl = 2'b00;
                endcase
                // C,V only follow arithmetic ops; N,Z follow every flag-setting op
                if (Funct[0] && CondEx)
                    w_fw = {(w_cmd == 4'b0100) || (w_cmd == 4'b0010) || w_is_cmp, 1'b1};
            end
            S_ALUWB: begin
                w_rw  = CondEx;
                w_pcw = CondEx & w_pc_dest;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pcw     = CondEx;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // State is forced to FETCH asynchronously, so only the enables need masking
    assign PCWrite   = w_pcw & ~reset;
    assign IRWrite   = w_irw & ~reset;
    assign RegWrite  = w_rw & ~reset;
    assign MemWrite  = w_mw & ~reset;
    assign FlagWrite = w_fw & {2{~reset}};
    assign ImmSrc    = Op;
    assign RegSrc    = {Op == 2'b01, Op == 2'b10};
    assign State     = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized bench for multicycle_controller against an instruction-level model
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       CondEx;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, FlagWrite;
    logic [3:0] State;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .CondEx(CondEx),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .FlagWrite(FlagWrite),
        .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, irw, rw, mw, adr, asa;
        logic [1:0] asb, rs, alc, imm, rsrc, fw;
    } outs_t;

    int         errors = 0;
    int         checks = 0;
    logic       chk_en = 1'b0;
    int         exp_state = 0;
    logic [31:0] obs = '0;
    int         rw_cnt = 0, mw_cnt = 0;
    logic       cap_pcw4 = 1'b0, cap_br_pcw = 1'b0;
    logic [3:0] cap_br_sel = '0;
    logic [1:0] cap_alu = '0, cap_fw = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t state=%0d)", name, act, exp, $time, exp_state);
        end
    endtask

    // Walk of states an instruction takes, FETCH first
    function automatic void inst_path(input logic [1:0] op, input logic [5:0] funct, output int q[$]);
        q = {0, 1};
        case (op)
            2'd1: if (funct[0]) q = {0, 1, 2, 3, 4}; else q = {0, 1, 2, 5};
            2'd0: begin
                q.push_back(funct[5] ? 7 : 6);
                if (funct[4:1] != 4'd10) q.push_back(8);
            end
            2'd2: q.push_back(9);
            default: ;
        endcase
    endfunction

    function automatic outs_t model(input int st, input logic [1:0] op, input logic [5:0] funct,
                                    input logic [3:0] rd, input logic ce);
        outs_t o;
        int cmd;
        o = '0;
        cmd = int'(funct[4:1]);
        o.imm  = op;
        o.rsrc = {op == 2'd1, op == 2'd2};
        case (st)
            0: begin o.asa = 1; o.asb = 2; o.rs = 2; o.irw = 1; o.pcw = 1; end
            1: begin o.asa = 1; o.asb = 2; o.rs = 2; end
            2: o.asb = 1;
            3: o.adr = 1;
            4: begin o.rs = 1; o.rw = ce; o.pcw = ce && rd == 15; end
            5: begin o.adr = 1; o.mw = ce; end
            6, 7: begin
                o.asb = (st == 7) ? 2'd1 : 2'd0;
                o.alc = (cmd == 2 || cmd == 10) ? 2'd1 : (cmd == 0) ? 2'd2 : (cmd == 12) ? 2'd3 : 2'd0;
                if (funct[0] && ce) o.fw = {cmd == 4 || cmd == 2 || cmd == 10, 1'b1};
            end
            8: begin o.rw = ce; o.pcw = ce && rd == 15; end
            9: begin o.asb = 1; o.rs = 2; o.pcw = ce; end
            default: ;
        endcase
        return o;
    endfunction

    always @(negedge clk) begin
        outs_t e;
        if (chk_en) begin
            e = model(exp_state, Op, Funct, Rd, CondEx);
            check("state", State, exp_state);
            check("enables", {PCWrite, IRWrite, RegWrite, MemWrite}, {e.pcw, e.irw, e.rw, e.mw});
            check("selects", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, {e.adr, e.asa, e.asb, e.rs});
            check("alucontrol", ALUControl, e.alc);
            check("flagwrite", FlagWrite, e.fw);
            check("immsrc_regsrc", {ImmSrc, RegSrc}, {e.imm, e.rsrc});
            obs    <= {obs[27:0], State};
            rw_cnt <= rw_cnt + int'(RegWrite);
            mw_cnt <= mw_cnt + int'(MemWrite);
            if (State == 4'd4) cap_pcw4 <= PCWrite;
            if (State == 4'd9) begin
                cap_br_pcw <= PCWrite;
                cap_br_sel <= {ALUSrcB, ResultSrc};
            end
            if (State == 4'd6 || State == 4'd7) begin
                cap_alu <= ALUControl;
                cap_fw  <= FlagWrite;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, State, 0);
        check({tag, "_enables"}, {PCWrite, IRWrite, RegWrite, MemWrite, FlagWrite}, 0);
        check({tag, "_selects"}, {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, 6'b0_1_10_10);
    endtask

    // Entered and left at posedge+1 with the DUT in FETCH; cmode 0/1 forces CondEx, 2 randomizes it
    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                             input int cmode, input int abort_k);
        int q[$];
        inst_path(op, funct, q);
        for (int i = 0; i < q.size(); i++) begin
            if (i == 0) begin
                Op = 2'($urandom); Funct = 6'($urandom); Rd = 4'($urandom);
            end else begin
                Op = op; Funct = funct; Rd = rd;
            end
            CondEx = (cmode == 2) ? 1'($urandom) : 1'(cmode);
            exp_state = q[i];
            chk_en = 1'b1;
            if (i == abort_k) begin
                #2;
                chk_en = 1'b0;
                reset = 1'b1;
                #1;
                check_reset_outputs("abort_now");
                @(posedge clk);
                #1;
                check_reset_outputs("abort_edge");
                reset = 1'b0;
                exp_state = 0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int r0, m0;
        reset = 1'b1; Op = 2'd1; Funct = 6'b011001; Rd = 4'd15; CondEx = 1'b1;
        #2;
        check_reset_outputs("reset_async");
        @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        reset = 1'b0;

        r0 = rw_cnt;
        run_instr(2'd1, 6'b011001, 4'd3, 1, -1);
        check("ldr_path", int'(obs[19:0]), 20'h01234);
        check("ldr_regwrites", rw_cnt - r0, 1);
        check("ldr_pcw_memwb", cap_pcw4, 0);

        m0 = mw_cnt;
        run_instr(2'd1, 6'b011000, 4'd3, 0, -1);
        check("str_path", int'(obs[15:0]), 16'h0125);
        check("str_memwrites", mw_cnt - m0, 0);

        r0 = rw_cnt;
        run_instr(2'd0, 6'b000101, 4'd2, 1, -1);
        check("subs_path", int'(obs[15:0]), 16'h0168);
        check("subs_alu", cap_alu, 1);
        check("subs_flags", cap_fw, 3);
        check("subs_regwrites", rw_cnt - r0, 1);

        r0 = rw_cnt;
        run_instr(2'd0, 6'b110101, 4'd0, 1, -1);
        check("cmp_path", int'(obs[11:0]), 12'h017);
        check("cmp_flags", cap_fw, 3);
        check("cmp_regwrites", rw_cnt - r0, 0);

        run_instr(2'd2, 6'b000000, 4'd0, 0, -1);
        check("b_path", int'(obs[11:0]), 12'h019);
        check("b_pcw_false", cap_br_pcw, 0);
        run_instr(2'd2, 6'b000000, 4'd0, 1, -1);
        check("b_pcw_true", cap_br_pcw, 1);
        check("b_selects", cap_br_sel, 4'b0110);

        r0 = rw_cnt; m0 = mw_cnt;
        run_instr(2'd3, 6'b111111, 4'd15, 1, -1);
        check("undef_path", int'(obs[7:0]), 8'h01);
        check("undef_writes", (rw_cnt - r0) + (mw_cnt - m0), 0);

        run_instr(2'd1, 6'b011001, 4'd3, 1, 3);
        run_instr(2'd0, 6'b001000, 4'd15, 1, -1);

        for (int n = 0; n < 400; n++) begin
            logic [1:0] op;
            logic [5:0] funct;
            logic [3:0] rd;
            int q[$];
            int k;
            op    = 2'($urandom_range(0, 3));
            funct = 6'($urandom);
            if ($urandom_range(0, 2) == 0) funct[4:1] = 4'b1010;
            rd    = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            inst_path(op, funct, q);
            k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
            run_instr(op, funct, rd, 2, k);
        end

        chk_en = 1'b0;
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
